// File: rtl/super_pkg.sv
// Shared fetch-interface types and the ITCM window check used by the
// instruction fetch responder.
package super_pkg;

  typedef logic [31:0] fetch_addr_t;
  typedef logic [63:0] fetch_data_t;

  // One in-flight response: valid marks a live slot, err marks a bus error.
  typedef struct packed {
    logic valid;
    logic err;
  } fetch_rsp_t;

  // Unsigned 32-bit offset compare, so addresses below the base wrap high
  // and fall out of range.
  function automatic logic itcm_in_range(input fetch_addr_t addr,
                                         input fetch_addr_t base,
                                         input fetch_addr_t size);
    fetch_addr_t offset;
    offset = addr - base;
    return offset < size;
  endfunction

endpackage

// File: rtl/instr_fetch_responder_pipe.sv
// Fixed-depth {valid, err} shift register that times each granted fetch so
// its response lines up with the SRAM read data.
module fetch_rsp_pipe
  import super_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  fetch_rsp_t in_i,
  output fetch_rsp_t out_o
);

  fetch_rsp_t stage_q [Depth];

  // NOTE: these stages are control state, not a data array; every valid bit
  // must clear on reset or stale responses would leak out afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignment lets every stage shift off the old
      // value of its neighbour regardless of statement order.
      stage_q[0] <= in_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_o = stage_q[Depth-1];

endmodule

// File: rtl/instr_fetch_responder.sv
// Responder for the 64-bit instruction fetch port in front of a fixed-latency
// ITCM: grants under an outstanding limit, answers strictly in order.
module instr_fetch_responder
  import super_pkg::*;
#(
  parameter logic [31:0] MemBase        = 32'h0000_0000,
  parameter logic [31:0] MemSizeBytes   = 32'h0001_0000,
  parameter int unsigned MemLatency     = 1,
  parameter int unsigned MaxOutstanding = 2,
  localparam int         AddrW          = $clog2(MemSizeBytes) - 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [63:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             stall_i,
  output logic             mem_req_o,
  output logic [AddrW-1:0] mem_addr_o,
  input  logic [63:0]      mem_rdata_i,
  output logic             busy_o,
  output logic [31:0]      fetch_cnt_o,
  output logic [15:0]      err_cnt_o
);

  localparam int              OutW   = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

  logic [OutW-1:0] outst_q, outst_d;
  logic [31:0]     fetch_cnt_q;
  logic [15:0]     err_cnt_q;
  logic            in_range;
  logic            retiring;
  fetch_rsp_t      rsp_in, rsp_out;

  assign retiring = rsp_out.valid;
  assign in_range = itcm_in_range(instr_addr_i, MemBase, MemSizeBytes);

  // A retiring response frees its slot in the same cycle, so a full window
  // can still accept one new fetch per cycle.
  assign instr_gnt_o = instr_req_i & ~stall_i & ((outst_q < MaxOut) | retiring);
  assign mem_req_o   = instr_gnt_o & in_range;
  assign mem_addr_o  = AddrW'((instr_addr_i - MemBase) >> 3);

  assign rsp_in.valid = instr_gnt_o;
  assign rsp_in.err   = instr_gnt_o & ~in_range;

  fetch_rsp_pipe #(
    .Depth(MemLatency)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .in_i  (rsp_in),
    .out_o (rsp_out)
  );

  assign instr_rvalid_o = rsp_out.valid;
  assign instr_err_o    = rsp_out.valid & rsp_out.err;
  assign instr_rdata_o  = (rsp_out.valid && !rsp_out.err) ? mem_rdata_i : 64'h0;

  // NOTE: give every always_comb output a default first; a path that leaves
  // it unassigned infers a latch.
  always_comb begin
    outst_d = outst_q;
    if (instr_gnt_o && !retiring)      outst_d = outst_q + 1'b1;
    else if (!instr_gnt_o && retiring) outst_d = outst_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_q     <= '0;
      fetch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      outst_q <= outst_d;
      if (instr_gnt_o) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (instr_err_o && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign busy_o      = (outst_q != '0);
  assign fetch_cnt_o = fetch_cnt_q;
  assign err_cnt_o   = err_cnt_q;

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_o |-> outst_q != '0);

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    outst_q <= MaxOut);

  a_addr_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_i && !instr_gnt_o) ##1 instr_req_i |-> $stable(instr_addr_i));

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: three instances cover latency 1,
// latency 2 with two outstanding, and latency 2 with one outstanding.
module tb_instr_fetch_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  // Instance 1: MemLatency=1, MaxOutstanding=2
  logic req1 = 0, stall1 = 0, gnt1, rvalid1, err1, mem_req1, busy1;
  logic [31:0] addr1 = '0, fcnt1;
  logic [63:0] rdata1, mem_rdata1;
  logic [12:0] mem_addr1;
  logic [15:0] ecnt1;

  // Instance 2: MemLatency=2, MaxOutstanding=2
  logic req2 = 0, stall2 = 0, gnt2, rvalid2, err2, mem_req2, busy2;
  logic [31:0] addr2 = '0, fcnt2;
  logic [63:0] rdata2, mem_rdata2;
  logic [12:0] mem_addr2;
  logic [15:0] ecnt2;

  // Instance 3: MemLatency=2, MaxOutstanding=1
  logic req3 = 0, stall3 = 0, gnt3, rvalid3, err3, mem_req3, busy3;
  logic [31:0] addr3 = '0, fcnt3;
  logic [63:0] rdata3, mem_rdata3;
  logic [12:0] mem_addr3;
  logic [15:0] ecnt3;

  instr_fetch_responder #(.MemLatency(1), .MaxOutstanding(2)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req1), .instr_addr_i(addr1),
    .instr_gnt_o(gnt1), .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1),
    .instr_err_o(err1), .stall_i(stall1), .mem_req_o(mem_req1),
    .mem_addr_o(mem_addr1), .mem_rdata_i(mem_rdata1), .busy_o(busy1),
    .fetch_cnt_o(fcnt1), .err_cnt_o(ecnt1));

  instr_fetch_responder #(.MemLatency(2), .MaxOutstanding(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req2), .instr_addr_i(addr2),
    .instr_gnt_o(gnt2), .instr_rvalid_o(rvalid2), .instr_rdata_o(rdata2),
    .instr_err_o(err2), .stall_i(stall2), .mem_req_o(mem_req2),
    .mem_addr_o(mem_addr2), .mem_rdata_i(mem_rdata2), .busy_o(busy2),
    .fetch_cnt_o(fcnt2), .err_cnt_o(ecnt2));

  instr_fetch_responder #(.MemLatency(2), .MaxOutstanding(1)) u_o1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req3), .instr_addr_i(addr3),
    .instr_gnt_o(gnt3), .instr_rvalid_o(rvalid3), .instr_rdata_o(rdata3),
    .instr_err_o(err3), .stall_i(stall3), .mem_req_o(mem_req3),
    .mem_addr_o(mem_addr3), .mem_rdata_i(mem_rdata3), .busy_o(busy3),
    .fetch_cnt_o(fcnt3), .err_cnt_o(ecnt3));

  // SRAM contents: a recognisable pattern derived from the doubleword index.
  function automatic logic [63:0] mem_word(input logic [12:0] idx);
    return {32'hC0DE_0000 | {19'd0, idx}, 32'h1234_5678 ^ {19'd0, idx}};
  endfunction

  localparam logic [63:0] Idle = 64'hDEAD_BEEF_DEAD_BEEF;

  // Fixed-latency SRAM models; the output shows Idle when no read was issued.
  logic [63:0] m1_q, m2a_q, m2b_q, m3a_q, m3b_q;
  always_ff @(posedge clk) begin
    m1_q  <= mem_req1 ? mem_word(mem_addr1) : Idle;
    m2a_q <= mem_req2 ? mem_word(mem_addr2) : Idle;
    m2b_q <= m2a_q;
    m3a_q <= mem_req3 ? mem_word(mem_addr3) : Idle;
    m3b_q <= m3a_q;
  end
  assign mem_rdata1 = m1_q;
  assign mem_rdata2 = m2b_q;
  assign mem_rdata3 = m3b_q;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req1 = 0; req2 = 0; req3 = 0;
    stall1 = 0; stall2 = 0; stall3 = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    total++; if (rvalid1 !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid1); else passed++;
    total++; if (rdata1 !== 64'h0) $display("FAIL reset_rdata: got %h want 0", rdata1); else passed++;
    total++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy1); else passed++;
    total++; if (fcnt1 !== 32'd0) $display("FAIL reset_fcnt: got %0d want 0", fcnt1); else passed++;
    total++; if (ecnt1 !== 16'd0) $display("FAIL reset_ecnt: got %0d want 0", ecnt1); else passed++;
    total++; if ({gnt1, mem_req1, err1} !== 3'b000) $display("FAIL reset_gnt_memreq_err: got %b want 000", {gnt1, mem_req1, err1}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk); req1 = 1; addr1 = 32'h0000_0010; #1;
    total++; if (gnt1 !== 1'b1) $display("FAIL single_gnt: got %b want 1", gnt1); else passed++;
    total++; if (mem_req1 !== 1'b1) $display("FAIL single_mem_req: got %b want 1", mem_req1); else passed++;
    total++; if (mem_addr1 !== 13'd2) $display("FAIL single_mem_addr: got %0d want 2", mem_addr1); else passed++;
    total++; if (rvalid1 !== 1'b0) $display("FAIL single_early_rvalid: got %b want 0", rvalid1); else passed++;
    @(negedge clk); req1 = 0; #1;
    total++; if (rvalid1 !== 1'b1) $display("FAIL single_rvalid: got %b want 1", rvalid1); else passed++;
    total++; if (rdata1 !== mem_word(13'd2)) $display("FAIL single_rdata: got %h want %h", rdata1, mem_word(13'd2)); else passed++;
    total++; if (err1 !== 1'b0) $display("FAIL single_err: got %b want 0", err1); else passed++;
    total++; if (fcnt1 !== 32'd1) $display("FAIL single_fcnt: got %0d want 1", fcnt1); else passed++;
    @(negedge clk); #1;
    total++; if ({rvalid1, busy1} !== 2'b00) $display("FAIL single_idle: got %b want 00", {rvalid1, busy1}); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int t = 0; t < 7; t++) begin
      @(negedge clk);
      req2  = (t < 4);
      addr2 = (t < 4) ? 32'(t * 8) : 32'h0;
      #1;
      total++; if (gnt2 !== (t < 4)) $display("FAIL b2b_gnt t=%0d: got %b want %b", t, gnt2, (t < 4)); else passed++;
      if (t < 4) begin
        total++; if (mem_addr2 !== 13'(t)) $display("FAIL b2b_mem_addr t=%0d: got %0d want %0d", t, mem_addr2, t); else passed++;
      end
      total++; if (rvalid2 !== (t >= 2 && t < 6)) $display("FAIL b2b_rvalid t=%0d: got %b want %b", t, rvalid2, (t >= 2 && t < 6)); else passed++;
      if (t >= 2 && t < 6) begin
        total++; if (rdata2 !== mem_word(13'(t - 2))) $display("FAIL b2b_rdata t=%0d: got %h want %h", t, rdata2, mem_word(13'(t - 2))); else passed++;
      end
      total++; if (busy2 !== (t >= 1 && t <= 5)) $display("FAIL b2b_busy t=%0d: got %b want %b", t, busy2, (t >= 1 && t <= 5)); else passed++;
    end
    total++; if (fcnt2 !== 32'd4) $display("FAIL b2b_fcnt: got %0d want 4", fcnt2); else passed++;
  endtask

  task automatic test_interleave();
    do_reset();
    @(negedge clk); req2 = 1; addr2 = 32'h0000_0008; #1;
    total++; if ({gnt2, mem_req2} !== 2'b11) $display("FAIL ilv_first: got %b want 11", {gnt2, mem_req2}); else passed++;
    @(negedge clk); addr2 = 32'h0002_0000; #1;
    total++; if ({gnt2, mem_req2} !== 2'b10) $display("FAIL ilv_oor_memreq: got %b want 10", {gnt2, mem_req2}); else passed++;
    @(negedge clk); addr2 = 32'h0000_0010; #1;
    total++; if ({gnt2, mem_req2} !== 2'b11) $display("FAIL ilv_third: got %b want 11", {gnt2, mem_req2}); else passed++;
    total++; if ({rvalid2, err2} !== 2'b10) $display("FAIL ilv_rsp0: got %b want 10", {rvalid2, err2}); else passed++;
    total++; if (rdata2 !== mem_word(13'd1)) $display("FAIL ilv_rdata0: got %h want %h", rdata2, mem_word(13'd1)); else passed++;
    @(negedge clk); req2 = 0; #1;
    total++; if ({rvalid2, err2} !== 2'b11) $display("FAIL ilv_rsp1: got %b want 11", {rvalid2, err2}); else passed++;
    total++; if (rdata2 !== 64'h0) $display("FAIL ilv_rdata1: got %h want 0", rdata2); else passed++;
    @(negedge clk); #1;
    total++; if ({rvalid2, err2} !== 2'b10) $display("FAIL ilv_rsp2: got %b want 10", {rvalid2, err2}); else passed++;
    total++; if (rdata2 !== mem_word(13'd2)) $display("FAIL ilv_rdata2: got %h want %h", rdata2, mem_word(13'd2)); else passed++;
    total++; if (ecnt2 !== 16'd1) $display("FAIL ilv_ecnt_mid: got %0d want 1", ecnt2); else passed++;
    @(negedge clk); #1;
    total++; if (ecnt2 !== 16'd1) $display("FAIL ilv_ecnt: got %0d want 1", ecnt2); else passed++;
    total++; if (fcnt2 !== 32'd3) $display("FAIL ilv_fcnt: got %0d want 3", fcnt2); else passed++;
  endtask

  task automatic test_max_outstanding();
    int granted;
    granted = 0;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      req3  = 1;
      addr3 = 32'(granted * 8);
      #1;
      total++; if (gnt3 !== (t % 2 == 0)) $display("FAIL mo1_gnt t=%0d: got %b want %b", t, gnt3, (t % 2 == 0)); else passed++;
      total++; if (rvalid3 !== (t >= 2 && t % 2 == 0)) $display("FAIL mo1_rvalid t=%0d: got %b want %b", t, rvalid3, (t >= 2 && t % 2 == 0)); else passed++;
      if (t >= 2 && t % 2 == 0) begin
        total++; if (rdata3 !== mem_word(13'(t / 2 - 1))) $display("FAIL mo1_rdata t=%0d: got %h want %h", t, rdata3, mem_word(13'(t / 2 - 1))); else passed++;
      end
      total++; if (busy3 !== (t >= 1)) $display("FAIL mo1_busy t=%0d: got %b want %b", t, busy3, (t >= 1)); else passed++;
      if (t % 2 == 0) granted++;
    end
    @(negedge clk); req3 = 0;
    @(negedge clk); #1;
    total++; if ({busy3, err3, ecnt3 == 16'd0} !== 3'b001) $display("FAIL mo1_drain: got %b want 001", {busy3, err3, ecnt3 == 16'd0}); else passed++;
    total++; if (fcnt3 !== 32'd4) $display("FAIL mo1_fcnt: got %0d want 4", fcnt3); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk); req2 = 1; addr2 = 32'h0000_0008; #1;
    total++; if (gnt2 !== 1'b1) $display("FAIL stall_pre_gnt: got %b want 1", gnt2); else passed++;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk); stall2 = 1; addr2 = 32'h0000_0010; #1;
      total++; if ({gnt2, mem_req2} !== 2'b00) $display("FAIL stall_gnt t=%0d: got %b want 00", t, {gnt2, mem_req2}); else passed++;
      total++; if (rvalid2 !== (t == 2)) $display("FAIL stall_rvalid t=%0d: got %b want %b", t, rvalid2, (t == 2)); else passed++;
      if (t == 2) begin
        total++; if (rdata2 !== mem_word(13'd1)) $display("FAIL stall_rdata: got %h want %h", rdata2, mem_word(13'd1)); else passed++;
      end
    end
    @(negedge clk); stall2 = 0; #1;
    total++; if ({gnt2, mem_req2} !== 2'b11) $display("FAIL stall_release_gnt: got %b want 11", {gnt2, mem_req2}); else passed++;
    @(negedge clk); req2 = 0;
    @(negedge clk); #1;
    total++; if ({rvalid2, err2} !== 2'b10) $display("FAIL stall_late_rsp: got %b want 10", {rvalid2, err2}); else passed++;
    total++; if (rdata2 !== mem_word(13'd2)) $display("FAIL stall_late_rdata: got %h want %h", rdata2, mem_word(13'd2)); else passed++;
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    @(negedge clk); req2 = 1; addr2 = 32'h0000_0008;
    @(negedge clk); addr2 = 32'h0000_0010; #1;
    total++; if (gnt2 !== 1'b1) $display("FAIL rif_second_gnt: got %b want 1", gnt2); else passed++;
    @(negedge clk); rst_n = 0; req2 = 0; #1;
    total++; if (busy2 !== 1'b1) $display("FAIL rif_busy_before: got %b want 1", busy2); else passed++;
    @(negedge clk); rst_n = 1;
    for (int t = 0; t < 3; t++) begin
      #1;
      total++; if (rvalid2 !== 1'b0) $display("FAIL rif_stale_rvalid t=%0d: got %b want 0", t, rvalid2); else passed++;
      @(negedge clk);
    end
    #1;
    total++; if ({busy2, fcnt2 == 32'd0, ecnt2 == 16'd0} !== 3'b011) $display("FAIL rif_cleared: got %b want 011", {busy2, fcnt2 == 32'd0, ecnt2 == 16'd0}); else passed++;
    @(negedge clk); req2 = 1; addr2 = 32'h0000_0018; #1;
    total++; if ({gnt2, mem_addr2} !== {1'b1, 13'd3}) $display("FAIL rif_new_gnt: got %b/%0d want 1/3", gnt2, mem_addr2); else passed++;
    @(negedge clk); req2 = 0;
    @(negedge clk); #1;
    total++; if (rvalid2 !== 1'b1) $display("FAIL rif_new_rvalid: got %b want 1", rvalid2); else passed++;
    total++; if (rdata2 !== mem_word(13'd3)) $display("FAIL rif_new_rdata: got %h want %h", rdata2, mem_word(13'd3)); else passed++;
    total++; if (fcnt2 !== 32'd1) $display("FAIL rif_fcnt: got %0d want 1", fcnt2); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_interleave();
    test_max_outstanding();
    test_stall();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Responder end of the 64-bit instruction fetch interface driven by the IF stage prefetch buffer (req/addr -> gnt -> rvalid/rdata/err).
- Sits between the fetch port and a single-port, fixed-latency instruction SRAM (ITCM).
- Grants requests subject to an outstanding limit and an external stall.
- Returns one 64-bit response per grant, strictly in order. Out-of-range fetches complete with err and no SRAM access.

Parameters:
- MemBase, 32'h0000_0000, byte base address of the ITCM window.
- MemSizeBytes, 32'h0001_0000, window size; power of two, >= 8.
- MemLatency, 1, SRAM read latency in cycles (1..3).
- MaxOutstanding, 2, maximum granted-but-unanswered requests (1..4); must be >= MemLatency for full throughput.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address; bits [2:0] ignored
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid; cannot be back-pressured
- instr_rdata_o  out  64  fetched doubleword; 0 when err
- instr_err_o  out  1  bus error, qualified by rvalid
- stall_i  in  1  suppress grants this cycle (wait-state injection, refresh)
- mem_req_o  out  1  SRAM read enable
- mem_addr_o  out  $clog2(MemSizeBytes)-3  SRAM doubleword index
- mem_rdata_i  in  64  SRAM data, valid MemLatency cycles after mem_req_o
- busy_o  out  1  outstanding count != 0
- fetch_cnt_o  out  32  granted-fetch counter, wraps
- err_cnt_o  out  16  error-response counter, saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: all outputs 0, outstanding count 0, response pipeline cleared, both counters 0.
- Reset asserted mid-operation discards all in-flight responses. No rvalid is produced for them after reset releases.
- Grant rule: instr_gnt_o = instr_req_i & ~stall_i & (outst < MaxOutstanding | retiring).
  - "retiring" means instr_rvalid_o is high this cycle.
  - Grant is combinational, in the same cycle as the request.
- Range check:
  - in_range = (addr - MemBase) < MemSizeBytes, computed unsigned 32-bit. Wrap below MemBase therefore counts as out of range.
- On a grant:
  - In range: mem_req_o=1 and mem_addr_o=(addr-MemBase)>>3. Push {valid=1, err=0} into the response pipeline.
  - Out of range: mem_req_o=0. Push {valid=1, err=1}.
- mem_req_o is never asserted without a grant.
- Response pipeline: a MemLatency-deep shift register of {valid, err}, advanced every cycle.
  - The output stage drives instr_rvalid_o.
  - Data: instr_rdata_o = err ? 64'h0 : mem_rdata_i (no extra register).
- Latency: the response appears exactly MemLatency cycles after the grant. Error responses use the same latency, which preserves ordering.
- Throughput: one grant per cycle, sustained, when MaxOutstanding >= MemLatency.
- Outstanding count: +1 on grant, -1 on rvalid. Grant and rvalid in the same cycle leave it unchanged.
  - Never exceeds MaxOutstanding.
  - Underflow is impossible by construction; an SVA checks this.
- Counters:
  - fetch_cnt_o increments on every grant, in range or not, and wraps 32'hFFFF_FFFF->0.
  - err_cnt_o increments on rvalid&err and saturates.
- Handshake assumptions (SVA checks, not design requirements):
  - Once instr_req_i is asserted, instr_addr_i holds until granted.
  - The requester may drop req without a grant (branch redirect). No state changes in that case.
- stall_i only blocks new grants. In-flight responses still complete on schedule.
- busy_o = (outst != 0).

Decomposition:
- Response record typedef {valid, err} and the range-check helper function go in super_pkg alongside the fetch-interface types. Name them fetch_rsp_t and itcm_in_range().
- One sub-module, fetch_rsp_pipe: a parameterised-depth {valid, err} shift register with a synchronous clear. The top level holds the grant logic, range check, outstanding counter and statistics counters.

Test Plan:
- Single fetch, MemLatency=1, addr 0x0000_0010:
  - gnt in the same cycle, mem_addr_o=2.
  - rvalid one cycle later with rdata=mem_rdata_i, err=0.
  - fetch_cnt_o=1.
- Back-to-back fetches 0x0,0x8,0x10,0x18, MemLatency=2, MaxOutstanding=2:
  - Four consecutive grants.
  - Four consecutive rvalids starting at cycle 2, in order.
  - busy_o drops one cycle after the last rvalid.
- Interleaved 0x8, 0x0002_0000 (out of range), 0x10:
  - Responses in order: data, err with rdata=0, data.
  - mem_req_o low for the middle request; err_cnt_o=1.
- MaxOutstanding=1, MemLatency=2, continuous req:
  - Grants on alternate cycles only.
  - Grant coincides with rvalid when retiring is allowed; outstanding never exceeds 1.
- stall_i high for 3 cycles with req held:
  - No gnt during the stall; an in-flight response still arrives on time.
  - Grant in the first cycle stall_i is low.
- rst_ni asserted while 2 responses are in flight:
  - No rvalid after release, counters 0, busy_o=0.
  - The next request is granted normally.
